// File: rtl/hamming74_defs_pkg.sv
// Shared Hamming(7,4) constants, types and bit-layout helpers.
// Positions are 1-based Hamming positions; position p lives in codeword bit p-1.
package hamming74_defs_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;

    localparam int D0_POS = 3;
    localparam int D1_POS = 5;
    localparam int D2_POS = 6;
    localparam int D3_POS = 7;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SYN_W-1:0]  syn_t;

    localparam syn_t SYN_NONE = '0;

    function automatic data_t extract_data(input code_t code);
        return {code[D3_POS-1], code[D2_POS-1], code[D1_POS-1], code[D0_POS-1]};
    endfunction

    // One-hot mask selecting the bit a non-zero syndrome points at.
    function automatic code_t flip_mask(input syn_t syn);
        if (syn == SYN_NONE) begin
            return '0;
        end
        return code_t'(1) << (syn - syn_t'(1));
    endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) syndrome: the value is the 1-based position of a
// single flipped bit, or zero for a clean word.
module hamming74_syndrome
    import hamming74_defs_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [SYN_W-1:0]  o_syn
);

    assign o_syn[0] = i_code[0] ^ i_code[2] ^ i_code[4] ^ i_code[6];
    assign o_syn[1] = i_code[1] ^ i_code[2] ^ i_code[5] ^ i_code[6];
    assign o_syn[2] = i_code[3] ^ i_code[4] ^ i_code[5] ^ i_code[6];

endmodule

// File: rtl/hamming74_decode_pipe.sv
// Two-stage Hamming(7,4) decoder with valid/ready on both sides and
// saturating statistics counters for delivered and corrected words.
module hamming74_decode_pipe
    import hamming74_defs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syn,
    output logic             out_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] corr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_s1_valid;
    code_t            r_s1_code;
    syn_t             r_s1_syn;
    logic             r_s2_valid;
    data_t            r_out_data;
    syn_t             r_out_syn;
    logic             r_out_err;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_corr_cnt;

    syn_t             w_syn;
    code_t            w_corr_code;
    logic             w_s2_adv;
    logic             w_in_fire;
    logic             w_out_fire;

    hamming74_syndrome u_syndrome (
        .i_code (in_code),
        .o_syn  (w_syn)
    );

    // S2 frees up in the same cycle it hands off, so ready never depends on in_valid.
    assign w_s2_adv    = !r_s2_valid || out_ready;
    assign in_ready    = !r_s1_valid || w_s2_adv;
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = r_s2_valid && out_ready;
    assign w_corr_code = r_s1_code ^ flip_mask(r_s1_syn);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let S1's new word race into S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_code  <= in_code;
            r_s1_syn   <= w_syn;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_syn  <= '0;
            r_out_err  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= extract_data(w_corr_code);
                r_out_syn  <= r_s1_syn;
                r_out_err  <= (r_s1_syn != SYN_NONE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
            r_corr_cnt <= '0;
        end else if (clr_cnt) begin
            r_word_cnt <= '0;
            r_corr_cnt <= '0;
        end else if (w_out_fire) begin
            if (r_word_cnt != CNT_MAX) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (r_out_err && (r_corr_cnt != CNT_MAX)) begin
                r_corr_cnt <= r_corr_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign out_syn   = r_out_syn;
    assign out_err   = r_out_err;
    assign word_cnt  = r_word_cnt;
    assign corr_cnt  = r_corr_cnt;

endmodule

// File: tb/tb_hamming74_decode_pipe.sv
// Directed bench for hamming74_decode_pipe: vector table for decode results,
// hand-written sequences for latency, backpressure, saturation and reset.
module tb_hamming74_decode_pipe;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_code;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic [2:0]       out_syn;
    logic             out_err;
    logic             clr_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] corr_cnt;

    hamming74_decode_pipe #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_syn   (out_syn),
        .out_err   (out_err),
        .clr_cnt   (clr_cnt),
        .word_cnt  (word_cnt),
        .corr_cnt  (corr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] code;
        logic [3:0] data;
        logic [2:0] syn;
        logic       err;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic [2:0] syn;
        logic       err;
    } rx_t;

    vec_t       vecs [14];
    logic [6:0] tx_q [$];
    rx_t        rx_q [$];
    int         tx_idx;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
    endtask

    // Feeds tx_q from tx_idx and collects output transfers into rx_q until all
    // words are sent and n_expected have arrived, or the cycle budget runs out.
    task automatic pump(input int n_expected, input int budget);
        int  cyc;
        logic acc;
        cyc = 0;
        while ((tx_idx < tx_q.size() || rx_q.size() < n_expected) && cyc < budget) begin
            in_valid = (tx_idx < tx_q.size());
            in_code  = in_valid ? tx_q[tx_idx] : 7'h00;
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                rx_q.push_back('{data: out_data, syn: out_syn, err: out_err});
            end
            step();
            if (acc) tx_idx++;
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bp_exp [4];

        // data 1011 (7'h55) with every single-bit error first, then other patterns.
        vecs[0]  = '{7'h54, 4'b1011, 3'd1, 1'b1};
        vecs[1]  = '{7'h57, 4'b1011, 3'd2, 1'b1};
        vecs[2]  = '{7'h51, 4'b1011, 3'd3, 1'b1};
        vecs[3]  = '{7'h5D, 4'b1011, 3'd4, 1'b1};
        vecs[4]  = '{7'h45, 4'b1011, 3'd5, 1'b1};
        vecs[5]  = '{7'h75, 4'b1011, 3'd6, 1'b1};
        vecs[6]  = '{7'h15, 4'b1011, 3'd7, 1'b1};
        vecs[7]  = '{7'h55, 4'b1011, 3'd0, 1'b0};
        vecs[8]  = '{7'h00, 4'b0000, 3'd0, 1'b0};
        vecs[9]  = '{7'h7F, 4'b1111, 3'd0, 1'b0};
        vecs[10] = '{7'h07, 4'b0001, 3'd0, 1'b0};
        vecs[11] = '{7'h03, 4'b0001, 3'd3, 1'b1};
        vecs[12] = '{7'h5F, 4'b1111, 3'd6, 1'b1};
        // Double error (positions 1 and 2 of 7'h55) miscorrects at position 3.
        vecs[13] = '{7'h56, 4'b1010, 3'd3, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 7'h00;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_word_cnt", word_cnt, 0);
        check("reset_corr_cnt", corr_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Clean word with explicit two-cycle latency.
        in_valid = 1'b1;
        in_code  = 7'h55;
        step();
        in_valid = 1'b0;
        check("clean_lat1_out_valid", out_valid, 0);
        step();
        check("clean_out_valid", out_valid, 1);
        check("clean_out_data", out_data, 4'b1011);
        check("clean_out_syn", out_syn, 0);
        check("clean_out_err", out_err, 0);
        step();
        check("clean_bubble", out_valid, 0);
        check("clean_word_cnt", word_cnt, 1);
        check("clean_corr_cnt", corr_cnt, 0);

        clear_counters();
        for (int i = 0; i < 14; i++) begin
            tx_q.delete();
            rx_q.delete();
            tx_q.push_back(vecs[i].code);
            tx_idx = 0;
            pump(1, 10);
            check($sformatf("vec%0d_count", i), rx_q.size(), 1);
            if (rx_q.size() == 1) begin
                check($sformatf("vec%0d_data", i), rx_q[0].data, vecs[i].data);
                check($sformatf("vec%0d_syn", i), rx_q[0].syn, vecs[i].syn);
                check($sformatf("vec%0d_err", i), rx_q[0].err, vecs[i].err);
            end
            if (i == 6) begin
                check("sweep_word_cnt", word_cnt, 7);
                check("sweep_corr_cnt", corr_cnt, 7);
            end
        end

        // Backpressure: four words against a stalled output.
        clear_counters();
        out_ready = 1'b0;
        tx_q.delete();
        rx_q.delete();
        tx_q.push_back(7'h07);
        tx_q.push_back(7'h7F);
        tx_q.push_back(7'h45);
        tx_q.push_back(7'h00);
        bp_exp[0] = 4'b0001;
        bp_exp[1] = 4'b1111;
        bp_exp[2] = 4'b1011;
        bp_exp[3] = 4'b0000;
        tx_idx = 0;
        pump(0, 4);
        check("bp_accepted", tx_idx, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_hold_data0", out_data, 4'b0001);
        step();
        step();
        step();
        check("bp_hold_data1", out_data, 4'b0001);
        check("bp_hold_syn", out_syn, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_no_count", word_cnt, 0);
        out_ready = 1'b1;
        pump(4, 20);
        check("bp_rx_count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_q.size()) check($sformatf("bp_order%0d", i), rx_q[i].data, bp_exp[i]);
        end
        check("bp_word_cnt", word_cnt, 4);
        check("bp_corr_cnt", corr_cnt, 1);

        // Saturation at 2^CNT_W-1 with ten erroneous words.
        clear_counters();
        tx_q.delete();
        rx_q.delete();
        for (int i = 0; i < 10; i++) tx_q.push_back(7'h45);
        tx_idx = 0;
        pump(10, 40);
        check("sat_rx_count", rx_q.size(), 10);
        check("sat_word_cnt", word_cnt, 7);
        check("sat_corr_cnt", corr_cnt, 7);

        // Clear coinciding with an output transfer wins.
        in_valid = 1'b1;
        in_code  = 7'h45;
        step();
        in_valid = 1'b0;
        step();
        check("clr_xfer_out_valid", out_valid, 1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("clr_xfer_word_cnt", word_cnt, 0);
        check("clr_xfer_corr_cnt", corr_cnt, 0);

        // Reset with both stages full and non-zero counters.
        tx_q.delete();
        rx_q.delete();
        tx_q.push_back(7'h45);
        tx_idx = 0;
        pump(1, 10);
        check("pre_rst_word_cnt", word_cnt, 1);
        out_ready = 1'b0;
        tx_q.delete();
        tx_q.push_back(7'h7F);
        tx_q.push_back(7'h07);
        tx_idx = 0;
        pump(0, 3);
        check("pre_rst_full", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_corr_cnt", corr_cnt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_syn", out_syn, 0);
        check("rst_out_err", out_err, 0);
        step();
        step();
        check("rst_held_in_ready", in_ready, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 7'h55;
        rst_n     = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_lat1", out_valid, 0);
        step();
        check("post_rst_out_valid", out_valid, 1);
        check("post_rst_out_data", out_data, 4'b1011);
        check("post_rst_out_err", out_err, 0);
        step();
        check("post_rst_word_cnt", word_cnt, 1);
        check("post_rst_corr_cnt", corr_cnt, 0);
        check("post_rst_empty", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
